mux_nx1_rr_reg: RTL
===================

// Module: mux_nx1_rr_reg
// PURPOSE
//   Parametrised N-channel, WIDTH-bit registered multiplexer with a valid/ready handshake
//   on every input and on the output. It has two modes:
//     - direct select: a static select chooses the channel, like a plain NxM mux;
//     - round-robin:   a fair arbiter chooses among the valid channels.
//   One output register stage. It sits between several producers and one consumer,
//   in place of the combinational 2:1 data-flow mux wherever backpressure or fairness is needed.
// PARAMETERS
//   WIDTH  8  data width per channel, 1..64
//   N      4  number of input channels, 2..16
//   SEL_W  $clog2(N)  width of sel/out_ch (local, derived; not overridden)
// PORTS
//   clk       in   1          rising-edge clock
//   rst_n     in   1          asynchronous reset, active-low
//   in_data   in   N*WIDTH    channel i occupies bits [i*WIDTH +: WIDTH]
//   in_valid  in   N          channel i has data
//   in_ready  out  N          channel i data accepted this cycle (when in_valid[i] also high)
//   mode      in   1          0 = direct select, 1 = round-robin
//   sel       in   SEL_W      channel for mode 0; ignored in mode 1
//   out_data  out  WIDTH      registered output data
//   out_valid out  1          out_data/out_ch hold a word
//   out_ready in   1          consumer accepts the word this cycle
//   out_ch    out  SEL_W      index of the source channel of out_data
// BEHAVIOUR
//   Reset: async on rst_n low. Clears out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
//     in_ready is all-0 while rst_n is low. A word in flight at reset is dropped.
//   Load enable: ld = !out_valid || out_ready. Combinational path out_ready -> in_ready is allowed.
//   Grant g (combinational, at most one channel):
//     mode 0: g = sel when sel < N and in_valid[sel] = 1; otherwise no grant.
//             sel >= N never grants and never causes X.
//     mode 1: scan channels rr_ptr, rr_ptr+1, ... wrapping modulo N.
//             g = first channel with in_valid high; no grant if none are valid.
//   in_ready[i] = ld && (i == candidate), where candidate = sel (mode 0) or g (mode 1).
//     All other channels see in_ready = 0.
//   Transfer when ld and a grant exists. On the next edge: out_data <= in_data[g],
//     out_ch <= g, out_valid <= 1. Latency is 1 cycle; throughput is 1 word per cycle.
//   If ld and no grant: out_valid <= 0; out_data and out_ch hold their old values.
//   If !ld (out_valid=1, out_ready=0): all outputs hold, out_data is stable, in_ready is all 0.
//   rr_ptr: updates only on a transfer, in either mode: rr_ptr <= (g == N-1) ? 0 : g+1.
//     It holds otherwise. Result: a continuously valid channel waits at most N-1 grants.
//   Mode or sel change: sampled combinationally each cycle. A word already in the
//     output register is never altered. rr_ptr is kept across mode changes.
//   Simultaneous pop and push: out_ready=1 with a grant gives back-to-back transfer, no bubble.
// TESTING
//   T1 reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_ch=0,
//      in_ready=0 immediately, without a clock edge.
//   T2 mode 0 sweep: N=4, WIDTH=8, data ch0..3 = 0x11/0x22/0x33/0x44, all valid, out_ready=1,
//      sel=0..3 -> out_data 0x11..0x44 one cycle later, out_ch = sel.
//      Also N=3, sel=3 -> no grant, out_valid=0, in_ready=0.
//   T3 round-robin fairness: mode 1, all 4 channels valid, out_ready=1
//      -> out_ch sequence 0,1,2,3,0,...; in_valid=4'b1010 -> 1,3,1,3.
//   T4 backpressure: out_valid=1, out_ready=0 for 5 cycles -> out_data/out_ch stable,
//      in_ready=0; release -> next word the following cycle, nothing dropped or duplicated.
//   T5 all 8 combinations of WIDTH=1, N=2 in mode 0 (I0, I1, S0) -> Y = S0 ? I1 : I0,
//      delayed one cycle.
//   T6 random: mode/sel/valid/ready random for 10k cycles, checked against a scoreboard.
//      Every accepted input appears exactly once, in order, with the correct out_ch.

Source files
------------

// File: rtl/mux_nx1_rr_reg_if.sv
// Handshake bundle for mux_nx1_rr_reg: N producer channels in, one registered consumer port out.
// The master side drives the inputs and consumes the output. The slave side is the mux.
interface mux_nx1_rr_reg_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   out_ch;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/mux_nx1_rr_reg.sv
// N-channel registered mux with valid/ready on every port.
// Channel choice is either a static select (mode 0) or a round-robin arbiter (mode 1).
module mux_nx1_rr_reg #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_nx1_rr_reg_if.slave bus
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             ld;
  logic             sel_hit;
  logic             rr_found;
  logic [SEL_W-1:0] rr_g;
  logic [SEL_W:0]   idx;
  logic             grant;
  logic [SEL_W-1:0] g;
  logic [WIDTH-1:0] g_data;

  assign ld = !out_valid_q || bus.out_ready;

  // Static select only matches in-range channels, so sel >= N can never grant.
  always_comb begin
    sel_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bus.sel == SEL_W'(i) && bus.in_valid[i]) sel_hit = 1'b1;
    end
  end

  // Scan from rr_ptr upward, wrapping at N; the first valid channel wins.
  always_comb begin
    rr_found = 1'b0;
    rr_g     = '0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
      if (idx >= (SEL_W+1)'(N)) idx = idx - (SEL_W+1)'(N);
      if (!rr_found && bus.in_valid[idx[SEL_W-1:0]]) begin
        rr_found = 1'b1;
        rr_g     = idx[SEL_W-1:0];
      end
    end
  end

  assign grant = bus.mode ? rr_found : sel_hit;
  assign g     = bus.mode ? rr_g     : bus.sel;

  always_comb begin
    g_data = '0;
    for (int i = 0; i < N; i++) begin
      if (g == SEL_W'(i)) g_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Held low while in reset, even though the empty output register would otherwise allow a load.
  for (genvar gi = 0; gi < N; gi++) begin : g_rdy
    assign bus.in_ready[gi] = rst_n && ld &&
      (bus.mode ? (rr_found && rr_g == SEL_W'(gi)) : (bus.sel == SEL_W'(gi)));
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (ld) begin
      out_valid_d = grant;
      if (grant) begin
        out_data_d = g_data;
        out_ch_d   = g;
        rr_ptr_d   = (g == SEL_W'(N-1)) ? '0 : g + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
endmodule
